// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: operands are shifted LSB-first through a
// single comparator cell whose e/g outputs are registered and fed back each clock.
module serial_mag_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic             r_e;
   logic             r_g;
   logic [CW-1:0]    r_cnt;
   logic             w_e1;
   logic             w_g1;
   logic             w_load;
   logic             w_last;

   // Later (more significant) bits override the cascade, so LSB-first is correct.
   assign w_e1 = (r_sa[0] ~^ r_sb[0]) & r_e;
   assign w_g1 = (r_sa[0] & ~r_sb[0]) | ((r_sa[0] ~^ r_sb[0]) & r_g);

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_last = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load = 1'b1;
               w_next = SHIFT;
            end
         end
         SHIFT: begin
            if (r_cnt == LAST) begin
               w_last = 1'b1;
               w_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               w_load = 1'b1;
               w_next = SHIFT;
            end else begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sa  <= '0;
         r_sb  <= '0;
         r_e   <= 1'b1;
         r_g   <= 1'b0;
         r_cnt <= '0;
      end else if (w_load) begin
         r_sa  <= a;
         r_sb  <= b;
         r_e   <= 1'b1;
         r_g   <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == SHIFT) begin
         r_sa  <= r_sa >> 1;
         r_sb  <= r_sb >> 1;
         r_e   <= w_e1;
         r_g   <= w_g1;
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Result flags only move on completion so they stay stable mid-comparison.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
         eq   <= 1'b0;
         gt   <= 1'b0;
         lt   <= 1'b0;
      end else begin
         done <= w_last;
         if (w_load)      busy <= 1'b1;
         else if (w_last) busy <= 1'b0;
         if (w_last) begin
            eq <= w_e1;
            gt <= w_g1;
            lt <= ~w_e1 & ~w_g1;
         end
      end
   end

endmodule
